// File: rtl/result_collector_if.sv
// Bundle between the buffer controller / activation lanes and result_collector.
// The master drives job control and lane inputs. The slave (the collector) drives the buffer write port and status.
interface result_collector_if #(
  parameter int LANES = 16,
  parameter int DW    = 20,
  parameter int AW    = 10
);
  logic                  start;
  logic [AW-1:0]         base_addr;
  logic [6:0]            row_count;
  logic [LANES-1:0]      lane_valid;
  logic [LANES*DW-1:0]   lane_data;
  logic                  wr_en;
  logic [AW-1:0]         wr_addr;
  logic [LANES*DW-1:0]   wr_data;
  logic                  busy;
  logic                  done;
  logic                  overflow;
  logic [1:0]            dbg_state;

  modport master (
    output start, base_addr, row_count, lane_valid, lane_data,
    input  wr_en, wr_addr, wr_data, busy, done, overflow, dbg_state
  );

  modport slave (
    input  start, base_addr, row_count, lane_valid, lane_data,
    output wr_en, wr_addr, wr_data, busy, done, overflow, dbg_state
  );
endinterface

// File: rtl/result_collector.sv
// Realigns skewed activation lanes through per-lane FIFOs and writes full rows to consecutive buffer lines.
// Optional RESULT_COLLECTOR_SAT8_EN: saturate each lane to signed 8 bits and sign-extend before the write.
module result_collector #(
  parameter int LANES = 16,
  parameter int DW    = 20,
  parameter int DEPTH = 32,
  parameter int AW    = 10
) (
  input  logic             clk,
  input  logic             rst,
  result_collector_if.slave bus
);

  localparam int PW = $clog2(DEPTH) + 1;
  localparam int IW = PW - 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_COLLECT = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;

`ifdef RESULT_COLLECTOR_SAT8_EN
  localparam logic signed [DW-1:0] SAT_MAX = 127;
  localparam logic signed [DW-1:0] SAT_MIN = -128;

  function automatic logic [DW-1:0] shape(input logic [DW-1:0] v);
    logic signed [DW-1:0] s;
    s = signed'(v);
    if (s > SAT_MAX) return SAT_MAX;
    if (s < SAT_MIN) return SAT_MIN;
    return v;
  endfunction
`else
  function automatic logic [DW-1:0] shape(input logic [DW-1:0] v);
    return v;
  endfunction
`endif

  logic [1:0]                  state_q, state_d;
  logic [AW-1:0]               base_q, base_d;
  logic [6:0]                  cnt_q, cnt_d;
  logic [6:0]                  row_idx_q, row_idx_d;
  logic                        overflow_q, overflow_d;
  logic                        wr_en_q, wr_en_d;
  logic [AW-1:0]               wr_addr_q, wr_addr_d;
  logic [LANES*DW-1:0]         wr_data_q, wr_data_d;
  logic [LANES-1:0][PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [LANES-1:0][PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [DW-1:0]               fifo_mem_q [LANES][DEPTH];

  logic                        collecting;
  logic                        rows_left;
  logic                        row_fire;
  logic [LANES-1:0]            empty, full, push_req, avail, pop, store, drop;
  logic [LANES*DW-1:0]         row_word;
  logic [DW-1:0]               lane_in, lane_word;

  // Lanes carry valid only, no backpressure: a word is offered in the cycle lane_valid is high and is either
  // stored, bypassed straight into the row being written, or dropped when its FIFO is full and not popping.
  always_comb begin
    collecting = (state_q == S_COLLECT);
    rows_left  = (row_idx_q != cnt_q);
    empty      = '0;
    full       = '0;
    push_req   = '0;
    avail      = '0;
    pop        = '0;
    store      = '0;
    drop       = '0;
    row_word   = '0;
    lane_in    = '0;
    lane_word  = '0;
    for (int i = 0; i < LANES; i++) begin
      empty[i]    = (wr_ptr_q[i] == rd_ptr_q[i]);
      full[i]     = (wr_ptr_q[i][PW-1] != rd_ptr_q[i][PW-1]) &&
                    (wr_ptr_q[i][IW-1:0] == rd_ptr_q[i][IW-1:0]);
      push_req[i] = collecting & bus.lane_valid[i];
      avail[i]    = ~empty[i] | push_req[i];
    end
    row_fire = collecting & rows_left & (&avail);
    // An empty lane that is pushing completes the row through the bypass, keeping write latency at one cycle.
    for (int i = 0; i < LANES; i++) begin
      lane_in   = bus.lane_data[i*DW +: DW];
      lane_word = empty[i] ? lane_in : fifo_mem_q[i][rd_ptr_q[i][IW-1:0]];
      row_word[i*DW +: DW] = shape(lane_word);
      pop[i]   = row_fire & ~empty[i];
      drop[i]  = push_req[i] & full[i] & ~pop[i];
      store[i] = push_req[i] & ~(row_fire & empty[i]) & ~drop[i];
    end
  end

  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    cnt_d      = cnt_q;
    row_idx_d  = row_idx_q;
    overflow_d = overflow_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d    = S_COLLECT;
          base_d     = bus.base_addr;
          cnt_d      = bus.row_count;
          row_idx_d  = '0;
          overflow_d = 1'b0;
        end
      end
      S_COLLECT: begin
        for (int i = 0; i < LANES; i++) begin
          wr_ptr_d[i] = wr_ptr_q[i] + PW'(store[i]);
          rd_ptr_d[i] = rd_ptr_q[i] + PW'(pop[i]);
        end
        if (|drop) overflow_d = 1'b1;
        if (row_fire) begin
          wr_en_d   = 1'b1;
          wr_addr_d = base_q + AW'(row_idx_q);
          wr_data_d = row_word;
          row_idx_d = row_idx_q + 7'd1;
        end
        // Leaving one cycle after the last row keeps busy high while the final write is on the bus.
        if (!rows_left) state_d = S_DONE;
      end
      S_DONE: begin
        state_d  = S_IDLE;
        wr_ptr_d = '0;
        rd_ptr_d = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      cnt_q      <= '0;
      row_idx_q  <= '0;
      overflow_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      cnt_q      <= cnt_d;
      row_idx_q  <= row_idx_d;
      overflow_q <= overflow_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (store[i]) fifo_mem_q[i][wr_ptr_q[i][IW-1:0]] <= bus.lane_data[i*DW +: DW];
    end
  end

  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign bus.busy      = (state_q == S_COLLECT);
  assign bus.done      = (state_q == S_DONE);
  assign bus.overflow  = overflow_q;
  assign bus.dbg_state = state_q;

endmodule
